// File: rtl/elliptic_curve_structs.sv
// ============================================================================
// elliptic_curve_structs : curve constants, datapath defaults, FSM state type
// Rev 1.1 - limb-serial add/sub state enum and width/limb defaults
// ============================================================================
`default_nettype none

package elliptic_curve_structs;

  localparam int DEFAULT_WIDTH = 256;
  localparam int DEFAULT_LIMB  = 32;

  // secp256k1 field prime: 2^256 - 2^32 - 977
  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef struct packed {
    logic [255:0] n;
  } curve_params_t;

  localparam curve_params_t CURVE_PARAMS = '{n: SECP256K1_P};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } addsub_state_e;

  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/limb_addsub_cell.sv
// ============================================================================
// limb_addsub_cell : one limb of the two chained add/sub carry chains
// Rev 1.0
// ============================================================================
`default_nettype none

module limb_addsub_cell #(
  parameter int LIMB = 32
) (
  input  logic [LIMB-1:0] a_l,
  input  logic [LIMB-1:0] b_l,
  input  logic [LIMB-1:0] n_l,
  input  logic            op,
  input  logic            c1_in,
  input  logic            c2_in,
  output logic [LIMB-1:0] t1_l,
  output logic [LIMB-1:0] t2_l,
  output logic            c1_out,
  output logic            c2_out
);

  logic [LIMB:0] s1;
  logic [LIMB:0] s2;

  // The extra top bit is the carry (add) or the borrow (subtract).
  always_comb begin
    s1 = '0;
    s2 = '0;
    if (!op) begin
      s1 = {1'b0, a_l} + {1'b0, b_l} + {{LIMB{1'b0}}, c1_in};
    end else begin
      s1 = {1'b0, a_l} - {1'b0, b_l} - {{LIMB{1'b0}}, c1_in};
    end
    t1_l   = s1[LIMB-1:0];
    c1_out = s1[LIMB];

    if (!op) begin
      s2 = {1'b0, t1_l} - {1'b0, n_l} - {{LIMB{1'b0}}, c2_in};
    end else begin
      s2 = {1'b0, t1_l} + {1'b0, n_l} + {{LIMB{1'b0}}, c2_in};
    end
    t2_l   = s2[LIMB-1:0];
    c2_out = s2[LIMB];
  end

endmodule

`default_nettype wire

// File: rtl/mod_addsub_serial.sv
// ============================================================================
// mod_addsub_serial : limb-serial (a +/- b) mod n with start/done handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_addsub_serial
  import elliptic_curve_structs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LIMB  = DEFAULT_LIMB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int NLIMBS = WIDTH / LIMB;
  localparam int CNT_W  = cnt_width(NLIMBS);
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NLIMBS - 1);

  addsub_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             c1_q, c1_d;
  logic             c2_q, c2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] t1_q, t1_d;
  logic [WIDTH-1:0] t2_q, t2_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [LIMB-1:0]       t1_l, t2_l;
  logic                  c1_out, c2_out;
  logic [WIDTH+LIMB-1:0] t1_cat, t2_cat;
  logic                  use_t2;

  // Operands shift right each RUN cycle, so the cell always sees limb 0.
  limb_addsub_cell #(
    .LIMB (LIMB)
  ) u_cell (
    .a_l    (a_q[LIMB-1:0]),
    .b_l    (b_q[LIMB-1:0]),
    .n_l    (n_q[LIMB-1:0]),
    .op     (op_q),
    .c1_in  (c1_q),
    .c2_in  (c2_q),
    .t1_l   (t1_l),
    .t2_l   (t2_l),
    .c1_out (c1_out),
    .c2_out (c2_out)
  );

  assign t1_cat = {t1_l, t1_q};
  assign t2_cat = {t2_l, t2_q};

  // Add: wrapped sum (c1) or no borrow against n (!c2) means t1 >= n.
  // Sub: a borrow means a < b, so the n-corrected value is the answer.
  assign use_t2 = op_q ? c1_q : (c1_q | ~c2_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          op_d    = op;
          cnt_d   = '0;
          c1_d    = 1'b0;
          c2_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        c1_d  = c1_out;
        c2_d  = c2_out;
        a_d   = a_q >> LIMB;
        b_d   = b_q >> LIMB;
        n_d   = n_q >> LIMB;
        t1_d  = t1_cat[WIDTH+LIMB-1:LIMB];
        t2_d  = t2_cat[WIDTH+LIMB-1:LIMB];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_LIMB) begin
          state_d = FIN;
        end
      end
      FIN: begin
        result_d = use_t2 ? t2_q : t1_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == FIN);
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_addsub_serial.sv
// ============================================================================
// tb_mod_addsub_serial : vector table, corner sequences and random ops
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mod_addsub_serial;
  import elliptic_curve_structs::*;

  localparam logic [255:0] P   = SECP256K1_P;
  localparam logic [255:0] N64 = 256'hFFFFFFFF_00000001;

  logic clk = 1'b0;
  logic rst_n;

  logic         start_a, op_a, busy_a, done_a;
  logic [255:0] a_a, b_a, n_a, result_a;
  logic         start_b, op_b, busy_b, done_b;
  logic [63:0]  a_b, b_b, n_b, result_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mod_addsub_serial #(.WIDTH(256), .LIMB(32)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a),
    .a(a_a), .b(b_a), .n(n_a),
    .busy(busy_a), .done(done_a), .result(result_a)
  );

  mod_addsub_serial #(.WIDTH(64), .LIMB(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b),
    .a(a_b), .b(b_b), .n(n_b),
    .busy(busy_b), .done(done_b), .result(result_b)
  );

  typedef struct {
    bit           sel;
    bit           op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
    int           lat;
  } vec_t;

  // Reference: plain wide-integer modular arithmetic.
  function automatic logic [255:0] ref_mod(input bit op, input logic [255:0] a,
                                           input logic [255:0] b, input logic [255:0] n);
    logic [257:0] s;
    if (!op) begin
      s = {2'b0, a} + {2'b0, b};
      if (s >= {2'b0, n}) s = s - {2'b0, n};
    end else if (a >= b) begin
      s = {2'b0, a} - {2'b0, b};
    end else begin
      s = {2'b0, a} + {2'b0, n} - {2'b0, b};
    end
    return s[255:0];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op, scramble inputs after sampling, wait for done (bounded).
  task automatic run(input bit sel, input bit op, input logic [255:0] a,
                     input logic [255:0] b, output logic [255:0] res,
                     output int lat, output bit busy_ok);
    if (!sel) begin
      op_a = op; a_a = a; b_a = b; n_a = P; start_a = 1'b1;
    end else begin
      op_b = op; a_b = a[63:0]; b_b = b[63:0]; n_b = N64[63:0]; start_b = 1'b1;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (!sel) begin
      op_a = ~op_a; a_a = {8{$urandom}}; b_a = {8{$urandom}}; n_a = {8{$urandom}};
    end else begin
      op_b = ~op_b; a_b = {2{$urandom}}; b_b = {2{$urandom}}; n_b = {2{$urandom}};
    end
    lat     = 0;
    busy_ok = 1'b1;
    while (!(sel ? done_b : done_a) && lat < 40) begin
      if (!(sel ? busy_b : busy_a)) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = sel ? {192'b0, result_b} : result_a;
  endtask

  function automatic logic [255:0] rand_below(input logic [255:0] n, input bit sel);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    if (sel) v[255:64] = '0;
    if (v >= n) v = v - n;
    return v;
  endfunction

  initial begin
    vec_t         tbl[10];
    logic [255:0] res, res2, ra, rb, rn;
    int           lat, nd;
    bit           bok, rop, rsel;

    tbl[0] = '{0, 0, 256'd5,          256'd7,   256'd12,               9};
    tbl[1] = '{0, 0, P - 256'd1,      256'd2,   256'd1,                9};
    tbl[2] = '{0, 0, 256'hFFFFFFFF,   256'd1,   256'h1_00000000,       9};
    tbl[3] = '{0, 0, P - 256'd1,      P - 256'd1, P - 256'd2,          9};
    tbl[4] = '{0, 1, 256'd3,          256'd5,   P - 256'd2,            9};
    tbl[5] = '{0, 1, 256'h1234,       256'h1234, 256'd0,               9};
    tbl[6] = '{0, 1, P - 256'd1,      256'd0,   P - 256'd1,            9};
    tbl[7] = '{1, 0, N64 - 256'd1,    N64 - 256'd1, N64 - 256'd2,      5};
    tbl[8] = '{1, 1, 256'd0,          256'd1,   N64 - 256'd1,          5};
    tbl[9] = '{1, 0, 256'hFFFF,       256'd1,   256'h10000,            5};

    start_a = 0; op_a = 0; a_a = '0; b_a = '0; n_a = '0;
    start_b = 0; op_b = 0; a_b = '0; b_b = '0; n_b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {255'b0, busy_a}, 256'd0);
    check("reset_done",   {255'b0, done_a}, 256'd0);
    check("reset_result", result_a,         256'd0);
    check("reset_res64",  {192'b0, result_b}, 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, res, lat, bok);
      check($sformatf("vec%0d_result", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), 256'(lat), 256'(tbl[i].lat));
      check($sformatf("vec%0d_busy_run", i), {255'b0, bok}, 256'd1);
      check($sformatf("vec%0d_busy_done", i),
            {255'b0, (tbl[i].sel ? busy_b : busy_a)}, 256'd0);
    end

    // Back-to-back: second start presented in the done cycle.
    run(0, 0, 256'd100, 256'd200, res, lat, bok);
    check("b2b_first", res, 256'd300);
    run(0, 1, 256'd5, 256'd7, res2, lat, bok);
    check("b2b_second", res2, P - 256'd2);
    check("b2b_latency", 256'(lat), 256'd9);

    // Start pulsed during RUN must be ignored.
    @(posedge clk); #1;
    op_a = 0; a_a = 256'd10; b_a = 256'd20; n_a = P; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    op_a = 1; a_a = 256'd1; b_a = 256'd2; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    nd = 0;
    res = '0;
    for (int k = 0; k < 25; k++) begin
      if (done_a) begin
        nd++;
        res = result_a;
      end
      @(posedge clk); #1;
    end
    check("ignore_done_count", 256'(nd), 256'd1);
    check("ignore_result", res, 256'd30);

    // Reset while processing limb 4: abort, no done.
    op_a = 0; a_a = 256'd9; b_a = 256'd9; n_a = P; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy",   {255'b0, busy_a}, 256'd0);
    check("abort_done",   {255'b0, done_a}, 256'd0);
    check("abort_result", result_a,         256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    check("abort_no_done", 256'(nd), 256'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      rsel = (i % 3 == 2);
      rn   = rsel ? N64 : P;
      ra   = rand_below(rn, rsel);
      rb   = (i % 8 == 5) ? ra : rand_below(rn, rsel);
      rop  = 1'($urandom_range(0, 1));
      run(rsel, rop, ra, rb, res, lat, bok);
      check($sformatf("rand%0d_result", i), res, ref_mod(rop, ra, rb, rn));
      check($sformatf("rand%0d_latency", i), 256'(lat), rsel ? 256'd5 : 256'd9);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_addsub_serial.md
Name: mod_addsub_serial

Overview:
Limb-serial modular adder/subtractor: computes (a + b) mod n or (a - b) mod n over WIDTH-bit operands, processing LIMB bits per clock.
- Successor to the combinational 256-bit modular add. Width and limb size are parametrised, and the modulus is a runtime input rather than the fixed curve constant.
- Adds a start/done handshake, so the point-arithmetic sequencers can share one narrow datapath instead of a full-width carry chain.

Parameters:
WIDTH, 256, operand/modulus width in bits; must be a multiple of LIMB
LIMB, 32, bits processed per clock
NLIMBS, WIDTH/LIMB, derived localparam; limb count and RUN length

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  1  0: a+b mod n; 1: a-b mod n; latched with start
a  input  WIDTH  operand, caller guarantees a < n; latched with start
b  input  WIDTH  operand, caller guarantees b < n; latched with start
n  input  WIDTH  modulus, odd, n > 2; latched with start
busy  output  1  high in RUN and FIN
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  modular result; held from done until the next done

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; busy=0, done=0, result=0.
  - All operand, partial-sum and carry registers go to 0.
  - Reset mid-RUN/FIN aborts the operation; no done is produced.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - On a sampled start=1: latch a, b, n, op; clear limb counter, carry1 and carry2; go to RUN.
  - start=0 stays in IDLE.
  - done=0 except during the single cycle after FIN.
- RUN: one limb per edge, LSB limb first, limb index i = counter.
  - Chain 1: t1[i] = a[i] + b[i] + c1 (op=0), or a[i] - b[i] - c1 (op=1), with c1 as carry or borrow.
  - Chain 2, same cycle, fed by the chain-1 limb: t2[i] = t1[i] - n[i] - c2 (op=0), or t1[i] + n[i] + c2 (op=1).
  - Both t1 and t2 are stored in shift registers.
  - On the edge processing limb NLIMBS-1: keep final c1 and c2; go to FIN.
- FIN, one edge:
  - op=0: result = t2 if (c1=1, meaning a+b >= 2^WIDTH) or (c2=0, meaning t1 >= n); otherwise t1.
  - op=1: result = t2 if c1=1 (borrow, a<b); otherwise t1.
  - The chain-2 carry out of the top limb is discarded, which gives the wrap mod 2^WIDTH.
  - done=1 for exactly the following cycle; go to IDLE.
- Latency: start sampled at edge E; done high in the cycle after edge E+NLIMBS+1.
  - Throughput: one operation per NLIMBS+2 cycles.
  - A new start is accepted in the same cycle done is high.
- start while busy=1 is ignored, not queued.
- Changing a, b, n or op after the sampling edge has no effect.
- The result register updates only at FIN.
- Out-of-range inputs (a or b >= n) give unspecified values but must not hang the FSM.

Decomposition:
- Package elliptic_curve_structs:
  - Add a typedef for the FSM state enum (IDLE, RUN, FIN).
  - Default WIDTH/LIMB constants stay alongside the existing curve params (params.n is the usual value driven onto n).
- Sub-module limb_addsub_cell:
  - Combinational, parametrised by LIMB.
  - Inputs: a_l, b_l, n_l, op, c1_in, c2_in.
  - Outputs: t1_l, t2_l, c1_out, c2_out.
  - One instance. The FSM, counter and shift registers live in the top module.

Test Plan:
- Basic add, WIDTH=256, LIMB=32, n=secp256k1 p (2^256-2^32-977): op=0, a=5, b=7 -> result=12; done exactly 9 edges after the start-sampling edge; busy high for those cycles.
- Carry across limbs and wrap, same n: op=0, a=n-1, b=2 -> 1; op=0, a=0xFFFFFFFF, b=1 -> 0x1_00000000.
- Sum exceeds 2^256: op=0, a=b=n-1 -> n-2.
- Subtract: op=1, a=3, b=5 -> n-2; op=1, a=b=0x1234 -> 0; op=1, a=n-1, b=0 -> n-1.
- Control: start pulsed again during RUN is ignored, with exactly one done; back-to-back start in the done cycle -> second result correct; rst_n=0 at limb 4 -> busy=0, done never asserts, result=0.
- Generic config, WIDTH=64, LIMB=16, n=0xFFFFFFFF00000001: op=0, a=n-1, b=n-1 -> n-2 with done at 5 edges; op=1, a=0, b=1 -> n-1.
